// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto one blocking memory port, with a per-transaction wait timeout.
// Define ARB_RR_EN for round-robin arbitration; when it is undefined, LSU has fixed priority over IFU.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] RESP     = 2'd2;

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic        owner_lsu;  // current owner; after completion it doubles as last-granted
    logic        pick_lsu;

`ifdef ARB_RR_EN
    always_comb begin
        pick_lsu = lsu_req;
        if (ifu_req && lsu_req)
            pick_lsu = !owner_lsu;
    end
`else
    assign pick_lsu = lsu_req;
`endif

    assign lsu_gnt    = !reset && (state == IDLE) && lsu_req && pick_lsu;
    assign ifu_gnt    = !reset && (state == IDLE) && ifu_req && !pick_lsu;
    assign mem_req    = (state == WAIT_MEM);
    assign lsu_rvalid = (state == RESP) && owner_lsu;
    assign ifu_rvalid = (state == RESP) && !owner_lsu;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            owner_lsu <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= 4'b0000;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_req || lsu_req) begin
                        state     <= WAIT_MEM;
                        wait_cnt  <= '0;
                        owner_lsu <= pick_lsu;
                        if (pick_lsu) begin
                            mem_we    <= lsu_we;
                            mem_addr  <= lsu_addr;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= ifu_addr;
                            mem_wdata <= '0;
                            mem_wmask <= 4'b0000;
                        end
                    end
                end
                WAIT_MEM: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (mem_ack) begin
                        rsp_data <= mem_we ? 32'h0 : mem_rdata;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (wait_cnt == 16'(TIMEOUT)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
